serial_add_ctrl: RTL and testbench

Bit-serial adder controller. Accepts one pair of WIDTH-bit operands over a valid/ready handshake and sequences a single one-bit full-adder cell across them, LSB first, one bit per clock. The carry is held in a register between bits and the result is presented on a valid/ready output handshake. It is the sequencing layer over the one-bit adder datapath and trades latency for area against a ripple-carry array.

---
 rtl/serial_add_pkg.sv | 19 +
 rtl/serial_add_ctrl_fa_cell.sv | 13 +
 rtl/serial_add_ctrl.sv | 122 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding,
// WIDTH legality bounds and the counter-width helper.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;

  // Counter only needs to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// Combinational one-bit full adder, the only arithmetic in the serial adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one fa_cell sequenced LSB first, one bit per clock.
// Optional subtract mode (sub port, a - b) is enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned CW = cnt_width(WIDTH);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("serial_add_ctrl: WIDTH out of range");
  end

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic             fa_s, fa_co;
  logic             last_bit;

`ifdef SERIAL_ADD_SUB_EN
  // Two's-complement subtract: invert b and inject the +1 through the carry.
  assign b_in = sub ? ~b : b;
  assign c_in = sub | cin;
`else
  assign b_in = b;
  assign c_in = cin;
`endif

  fa_cell u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b_in;
            carry <= c_in;
            cnt   <= '0;
            sum   <= '0;
          end
        end
        RUN: begin
          // New bit enters at the MSB; after WIDTH shifts bit 0 lands in sum[0].
          sum   <= {fa_s, sum[WIDTH-1:1]};
          carry <= fa_co;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          cnt   <= cnt + 1'b1;
          if (last_bit) cout <= fa_co;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized self-checking bench for serial_add_ctrl against an arithmetic model.
// Honours SERIAL_ADD_SUB_EN when defined.
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {cout,sum} = a + b + cin (or a + ~b + 1 when subtracting), W+1 bits.
  function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                       input logic mc, input logic ms);
    logic [W:0] r;
`ifdef SERIAL_ADD_SUB_EN
    if (ms) r = {1'b0, ma} + {1'b0, ~mb} + (W+1)'(1);
    else    r = {1'b0, ma} + {1'b0, mb} + (W+1)'(mc);
`else
    r = {1'b0, ma} + {1'b0, mb} + (W+1)'(mc);
`endif
    return r;
  endfunction

  // One full transaction; poke re-drives in_valid with junk during RUN/DONE.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                        input logic ts, input int unsigned stall, input bit poke);
    logic [W:0]  exp;
    int unsigned n;
    exp = model(ta, tb_, tc, ts);
    @(negedge clk);
    a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b0;
    check("in_ready_idle", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    if (poke) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      in_valid = 1'b1;
    end
    check("busy_run", busy, 1'b1);
    n = 1;
    while (!out_valid && n < 4 * W) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    check("latency", n, W + 1);
    check("in_ready_done", in_ready, 1'b0);
    check("sum", sum, exp[W-1:0]);
    check("cout", cout, exp[W]);
    for (int unsigned i = 0; i < stall; i++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1'b1);
      check("hold_sum", {cout, sum}, exp);
      check("hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("in_ready_after", in_ready, 1'b1);
    check("valid_after", out_valid, 1'b0);
    check("sum_kept", {cout, sum}, exp);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_sum_cout", {cout, sum}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(8'h0F, 8'h01, 1'b0, 1'b0, 0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, 1'b0);
    run_op(8'h55, 8'hAA, 1'b0, 1'b0, 5, 1'b0);
    run_op(8'h3C, 8'h41, 1'b1, 1'b0, 1, 1'b1);
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 0, 1'b0);
`ifdef SERIAL_ADD_SUB_EN
    run_op(8'h05, 8'h07, 1'b0, 1'b1, 0, 1'b0);
    run_op(8'h07, 8'h05, 1'b0, 1'b1, 0, 1'b0);
`endif

    // Reset three cycles into RUN after a result that left cout=1.
    @(negedge clk);
    a = 8'hF0; b = 8'h0F; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_pre_rst", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_sum_cout", {cout, sum}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h12, 8'h34, 1'b0, 1'b0, 0, 1'b0);

    for (int unsigned k = 0; k < 20; k++) begin
      logic ks;
`ifdef SERIAL_ADD_SUB_EN
      ks = 1'($urandom);
`else
      ks = 1'b0;
`endif
      run_op(W'($urandom), W'($urandom), 1'($urandom), ks,
             $urandom_range(0, 3), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
